// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Purpose  : Shared types and width helpers for the radix-2 FFT stage
//            sequencer. The FSM state enum lives here, together with the
//            widths derived from LOG2_N (log2 of the FFT point count).
//            A package cannot take parameters, so the widths are constant
//            functions that each user evaluates with its own LOG2_N.
// Revision : 1.0 - initial release
// ============================================================================
package fft_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int LOG2_N_DEFAULT = 4;
    localparam int LOG2_N_MIN     = 2;
    localparam int LOG2_N_MAX     = 12;

    // Stage index width: holds 0..LOG2_N-1.
    function automatic int sw_of(input int log2_n);
        return (log2_n < 2) ? 1 : $clog2(log2_n);
    endfunction

    // Butterfly index / twiddle index width: 2^(LOG2_N-1) butterflies.
    function automatic int bw_of(input int log2_n);
        return log2_n - 1;
    endfunction

    // Completed-stage counter width: holds 0..LOG2_N.
    function automatic int cw_of(input int log2_n);
        return $clog2(log2_n + 1);
    endfunction

    localparam int SW = sw_of(LOG2_N_DEFAULT);
    localparam int BW = bw_of(LOG2_N_DEFAULT);
    localparam int CW = cw_of(LOG2_N_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/fft_stage_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_stage_sequencer_if
// Purpose  : Control/status bundle between the FFT top-level control
//            (master) and the stage sequencer (slave).
// Signals  : start, abort, stage_strobe      master -> slave
//            busy, stage_done, frame_done    slave  -> master
//            stage_idx, bfly_idx             current position in the frame
//            stage_count_out                 stages completed in the frame
//            addr_a, addr_b, twiddle_idx     butterfly operand addressing
// Revision : 1.0 - initial release
// ============================================================================
interface fft_stage_sequencer_if #(
    parameter int LOG2_N = 4
);
    import fft_pkg::*;

    localparam int SW = sw_of(LOG2_N);
    localparam int BW = bw_of(LOG2_N);
    localparam int CW = cw_of(LOG2_N);

    logic              start;
    logic              abort;
    logic              stage_strobe;
    logic              busy;
    logic              stage_done;
    logic              frame_done;
    logic [SW-1:0]     stage_idx;
    logic [BW-1:0]     bfly_idx;
    logic [CW-1:0]     stage_count_out;
    logic [LOG2_N-1:0] addr_a;
    logic [LOG2_N-1:0] addr_b;
    logic [BW-1:0]     twiddle_idx;

    modport master (
        output start, abort, stage_strobe,
        input  busy, stage_done, frame_done, stage_idx, bfly_idx,
               stage_count_out, addr_a, addr_b, twiddle_idx
    );

    modport slave (
        input  start, abort, stage_strobe,
        output busy, stage_done, frame_done, stage_idx, bfly_idx,
               stage_count_out, addr_a, addr_b, twiddle_idx
    );

endinterface
`default_nettype wire

// File: rtl/fft_stage_sequencer_bfly_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : fft_bfly_addr_gen
// Purpose  : Combinational radix-2 butterfly addressing. For stage s and
//            butterfly b, with j = b mod 2^s and g = b >> s:
//              addr_a = g*2^(s+1) + j, addr_b = addr_a + 2^s,
//              twiddle_idx = j << (LOG2_N-1-s).
//            All outputs are zero while busy_i is low.
// Ports    : stage_idx_i, bfly_idx_i, busy_i  -> addr_a_o, addr_b_o,
//            twiddle_idx_o
// Revision : 1.0 - initial release
// ============================================================================
module fft_bfly_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2_N = 4
) (
    input  wire logic [sw_of(LOG2_N)-1:0] stage_idx_i,
    input  wire logic [bw_of(LOG2_N)-1:0] bfly_idx_i,
    input  wire logic                     busy_i,
    output logic      [LOG2_N-1:0]        addr_a_o,
    output logic      [LOG2_N-1:0]        addr_b_o,
    output logic      [bw_of(LOG2_N)-1:0] twiddle_idx_o
);

    localparam int SW = sw_of(LOG2_N);
    localparam int BW = bw_of(LOG2_N);

    logic [BW-1:0]     low_mask;
    logic [BW-1:0]     j_part;
    logic [BW-1:0]     g_part;
    logic [SW-1:0]     tw_shift;
    logic [LOG2_N-1:0] addr_a_raw;

    always_comb begin
        // On the last stage 1<<s wraps to zero, so the mask becomes all ones.
        low_mask   = (BW'(1) << stage_idx_i) - BW'(1);
        j_part     = bfly_idx_i & low_mask;
        // g already sits at bit s; one more left shift places it at s+1.
        g_part     = bfly_idx_i & ~low_mask;
        addr_a_raw = {g_part, 1'b0} | {1'b0, j_part};
        tw_shift   = SW'(BW) - stage_idx_i;

        addr_a_o      = '0;
        addr_b_o      = '0;
        twiddle_idx_o = '0;
        if (busy_i) begin
            addr_a_o      = addr_a_raw;
            // Bit s of addr_a is always clear, so OR is the same as adding 2^s.
            addr_b_o      = addr_a_raw | (LOG2_N'(1) << stage_idx_i);
            twiddle_idx_o = j_part << tw_shift;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fft_stage_sequencer
// Purpose  : Radix-2 FFT stage/butterfly sequencer. Counts butterfly-complete
//            strobes, tracks butterfly index within the stage and stage index
//            within the frame, pulses stage_done/frame_done, and drives the
//            operand addresses and twiddle index for the butterfly datapath.
// Ports    : clk      system clock, rising edge
//            n_reset  asynchronous active-low reset
//            bus      fft_stage_sequencer_if slave (start/abort/strobe in,
//                     status, counters and addresses out)
// Params   : LOG2_N      log2 of FFT points (2..12)
//            EDGE_DETECT 1 = count rising edges of stage_strobe,
//                        0 = count every high cycle
// Revision : 1.0 - initial release
// ============================================================================
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2_N      = 4,
    parameter int EDGE_DETECT = 1
) (
    input  wire logic           clk,
    input  wire logic           n_reset,
    fft_stage_sequencer_if.slave bus
);

    localparam int SW = sw_of(LOG2_N);
    localparam int BW = bw_of(LOG2_N);
    localparam int CW = cw_of(LOG2_N);

    localparam logic [BW-1:0] BFLY_LAST  = '1;
    localparam logic [SW-1:0] STAGE_LAST = SW'(LOG2_N - 1);
    localparam logic          LEVEL_MODE = (EDGE_DETECT == 0);

    state_e        state_q, state_d;
    logic [BW-1:0] bfly_q, bfly_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [CW-1:0] scount_q, scount_d;
    logic          stage_done_q, stage_done_d;
    logic          frame_done_q, frame_done_d;
    logic          strobe_q;
    logic          strobe_cnt;

    // In level mode the history term is forced true so every high cycle counts.
    assign strobe_cnt = bus.stage_strobe & (LEVEL_MODE | ~strobe_q);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= IDLE;
            bfly_q       <= '0;
            stage_q      <= '0;
            scount_q     <= '0;
            stage_done_q <= 1'b0;
            frame_done_q <= 1'b0;
            strobe_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            bfly_q       <= bfly_d;
            stage_q      <= stage_d;
            scount_q     <= scount_d;
            stage_done_q <= stage_done_d;
            frame_done_q <= frame_done_d;
            // Tracked in every state, so a strobe held across start is not an edge.
            strobe_q     <= bus.stage_strobe;
        end
    end

    always_comb begin
        state_d      = state_q;
        bfly_d       = bfly_q;
        stage_d      = stage_q;
        scount_d     = scount_q;
        stage_done_d = 1'b0;
        frame_done_d = 1'b0;

        if (bus.abort) begin
            // Completed-stage count is kept so control can see how far it got.
            state_d = IDLE;
            bfly_d  = '0;
            stage_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d  = RUN;
                        bfly_d   = '0;
                        stage_d  = '0;
                        scount_d = '0;
                    end
                end
                RUN: begin
                    if (strobe_cnt) begin
                        if (bfly_q != BFLY_LAST) begin
                            bfly_d = bfly_q + BW'(1);
                        end else begin
                            bfly_d       = '0;
                            scount_d     = scount_q + CW'(1);
                            stage_done_d = 1'b1;
                            if (stage_q == STAGE_LAST) begin
                                stage_d      = '0;
                                frame_done_d = 1'b1;
                                state_d      = IDLE;
                            end else begin
                                stage_d = stage_q + SW'(1);
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.busy            = (state_q == RUN);
    assign bus.stage_done      = stage_done_q;
    assign bus.frame_done      = frame_done_q;
    assign bus.stage_idx       = stage_q;
    assign bus.bfly_idx        = bfly_q;
    assign bus.stage_count_out = scount_q;

    fft_bfly_addr_gen #(
        .LOG2_N (LOG2_N)
    ) u_addr_gen (
        .stage_idx_i   (stage_q),
        .bfly_idx_i    (bfly_q),
        .busy_i        (state_q == RUN),
        .addr_a_o      (bus.addr_a),
        .addr_b_o      (bus.addr_b),
        .twiddle_idx_o (bus.twiddle_idx)
    );

endmodule
`default_nettype wire

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Parametrised radix-2 FFT stage/butterfly sequencer: counts butterfly-complete strobes, tracks butterfly index within the current stage and stage index within the frame, and generates the butterfly operand addresses and the twiddle index for the butterfly datapath. It supersedes the fixed 4-bit stage counter. It adds a start/busy/abort handshake, per-stage and per-frame done pulses, and an optional rising-edge strobe qualifier. It sits between the FFT top-level control and the butterfly/memory datapath.

## Interface
- LOG2_N, default 4: log2 of FFT points; stages = LOG2_N, butterflies per stage = 2^(LOG2_N-1); legal range 2..12.
- EDGE_DETECT, default 1: 1 = count only rising edges of stage_strobe; 0 = count every cycle strobe is high.
- clk  in  1  system clock, all state on rising edge.
- n_reset  in  1  asynchronous active-low reset.
- start  in  1  begin a frame; honoured only in IDLE.
- abort  in  1  synchronous return to IDLE; highest priority.
- stage_strobe  in  1  butterfly-complete indication from datapath.
- busy  out  1  high in RUN.
- stage_done  out  1  one-cycle pulse after the last butterfly of each stage.
- frame_done  out  1  one-cycle pulse after the last butterfly of the last stage.
- stage_idx  out  SW=$clog2(LOG2_N)  current stage, 0..LOG2_N-1.
- bfly_idx  out  LOG2_N-1  current butterfly within stage.
- stage_count_out  out  $clog2(LOG2_N+1)  stages completed in current/last frame.
- addr_a, addr_b  out  LOG2_N  operand addresses of current butterfly.
- twiddle_idx  out  LOG2_N-1  twiddle ROM index of current butterfly.

## Operation
- States: IDLE, RUN.
- IDLE: busy=0; start=1 → RUN, bfly_idx=0, stage_idx=0, stage_count_out=0. Strobes ignored.
- RUN: a counted strobe (strobe & ~strobe_q if EDGE_DETECT, else strobe) advances the sequence:
  - bfly_idx < 2^(LOG2_N-1)-1: bfly_idx+1.
  - Last butterfly, stage_idx < LOG2_N-1: bfly_idx wraps to 0, stage_idx+1, stage_count_out+1, stage_done pulse.
  - Last butterfly of last stage: stage_count_out+1 (=LOG2_N), stage_done and frame_done pulse together, → IDLE.
- start in RUN is ignored.
- abort (any state) → IDLE; bfly_idx and stage_idx clear; stage_count_out holds; no done pulses. abort with a counted strobe on the same edge: abort wins.
- stage_count_out holds after frame_done until the next accepted start.
- strobe_q (previous-cycle strobe) updates every cycle in every state. A strobe held high across start therefore does not count in EDGE_DETECT mode.
- Address arithmetic, with s=stage_idx, j = bfly_idx mod 2^s, g = bfly_idx >> s:
  - addr_a = g·2^(s+1) + j
  - addr_b = addr_a + 2^s
  - twiddle_idx = j << (LOG2_N-1-s)
- addr_a, addr_b and twiddle_idx are forced to 0 when busy=0.

## Timing
- Reset values: state IDLE, busy 0, stage_done 0, frame_done 0, stage_idx 0, bfly_idx 0, stage_count_out 0, addresses/twiddle 0, strobe_q 0.
- start sampled at edge k → busy high from edge k; addresses for butterfly 0 stage 0 are valid in the same cycle.
- Counted strobe at edge k → counters updated at edge k; stage_done/frame_done registered high for exactly the cycle after edge k; busy falls at edge k on the final strobe.
- Addresses are combinational from registered counters: zero latency, no glitch-free guarantee; the datapath samples them on clk.
- Back-to-back: in EDGE_DETECT=0, a strobe every cycle advances one butterfly per cycle. In EDGE_DETECT=1, the maximum rate is one butterfly per 2 cycles.
- start on the cycle after frame_done is accepted; a new frame starts with no dead cycle beyond the IDLE cycle.

## Structure
- Shared package fft_pkg: state enum (IDLE, RUN), width localparams derived from LOG2_N (SW, BW = LOG2_N-1, CW = $clog2(LOG2_N+1)).
- Sub-module fft_bfly_addr_gen: purely combinational; inputs stage_idx, bfly_idx, busy; outputs addr_a, addr_b, twiddle_idx; parameter LOG2_N.
- Top contains the FSM, counters, edge qualifier and pulse registers.

## Test plan
- Reset mid-RUN (LOG2_N=3, after 5 strobes) → all outputs 0 immediately, IDLE; start afterwards → bfly 0, stage 0.
- LOG2_N=3, EDGE_DETECT=1, strobe toggling each cycle after start → stage_done after strobes 4, 8, 12; frame_done with strobe 12; stage_count_out=3 held; busy low.
- LOG2_N=3 address check:
  - stage 0 bfly 2 → a=4, b=5, tw=0
  - stage 1 bfly 3 → a=5, b=7, tw=2
  - stage 2 bfly 3 → a=3, b=7, tw=3
- EDGE_DETECT=1, strobe held high 10 cycles → exactly one butterfly counted; EDGE_DETECT=0, same stimulus → 10 counted.
- abort coincident with the 4th strobe (LOG2_N=3) → no stage_done, IDLE, stage_count_out unchanged at 0.
- start held high during RUN and strobes in IDLE → no effect on counters; stage_count_out keeps its last value.
